// File: rtl/ldm_stm_seq_pkg.sv
// Shared CPU constants for the block-transfer sequencer: FSM encoding,
// PC register index, word size and the latched request record.
package ldm_stm_seq_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RDBASE = 3'd1;
   localparam logic [2:0] ST_SETUP  = 3'd2;
   localparam logic [2:0] ST_XFER   = 3'd3;
   localparam logic [2:0] ST_WBACK  = 3'd4;
   localparam logic [2:0] ST_FIN    = 3'd5;

   localparam logic [3:0]  PC_IDX     = 4'd15;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   // Request fields captured when a transfer is accepted
   typedef struct packed {
      logic        is_load;
      logic        pre;
      logic        up;
      logic        wb;
      logic [3:0]  rn;
      logic [15:0] reglist;
   } ldm_req_t;

   // Index of the lowest set bit (0 when the mask is empty)
   function automatic logic [3:0] lowest_set(input logic [15:0] mask);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ldm_stm_seq_popcount16.sv
// Combinational population count of a 16-bit register list.
module popcount16 (
   input  logic [15:0] i_bits,
   output logic [4:0]  o_count
);

   // Sum the selected bits
   always_comb begin
      o_count = 5'd0;
      for (int i = 0; i < 16; i++) begin
         o_count = o_count + {4'd0, i_bits[i]};
      end
   end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: reads the base register, walks the
// register list in ascending order over a word memory handshake, and
// optionally writes the updated base back.
module ldm_stm_seq
   import ldm_stm_seq_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic        pre,
   input  logic        up,
   input  logic        wb,
   input  logic [3:0]  rn,
   input  logic [15:0] reglist,
   output logic [3:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic        write_reg,
   output logic [3:0]  w_addr,
   output logic [31:0] w_data,
   output logic        write_pc,
   output logic [31:0] pc_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   logic [2:0]        r_state;
   ldm_req_t          r_req;
   logic [15:0]       r_mask;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_wbval;
   logic [WAIT_W-1:0] r_wait;
   logic              r_error;

   logic [4:0]  w_n;
   logic [31:0] w_4n;
   logic [31:0] w_start_addr;
   logic [31:0] w_wbval;
   logic [3:0]  w_cur;
   logic [15:0] w_mask_next;
   logic        w_last;
   logic        w_skip_wb;
   logic        w_in_xfer;
   logic        w_ld_ack;

   popcount16 u_popcount (
      .i_bits  (r_req.reglist),
      .o_count (w_n)
   );

   assign w_4n        = {25'd0, w_n, 2'b00};
   assign w_wbval     = r_req.up ? (rd_data + w_4n) : (rd_data - w_4n);
   assign w_cur       = lowest_set(r_mask);
   assign w_mask_next = r_mask & (r_mask - 16'd1);
   assign w_last      = (w_mask_next == 16'd0);
   // A loaded base register keeps the loaded value instead of the writeback
   assign w_skip_wb   = r_req.is_load & r_req.reglist[r_req.rn];
   assign w_in_xfer   = (r_state == ST_XFER);
   assign w_ld_ack    = w_in_xfer & mem_ack & r_req.is_load;

   // Lowest word address of the block for each P/U addressing mode
   always_comb begin
      w_start_addr = rd_data;
      case ({r_req.pre, r_req.up})
         2'b01:   w_start_addr = rd_data;
         2'b11:   w_start_addr = rd_data + WORD_BYTES;
         2'b00:   w_start_addr = rd_data - w_4n + WORD_BYTES;
         default: w_start_addr = rd_data - w_4n;
      endcase
   end

   // Main sequencer with its registered datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_req   <= '0;
         r_mask  <= 16'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_wbval <= 32'd0;
         r_wait  <= '0;
         r_error <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_req   <= '{is_load: is_load, pre: pre, up: up, wb: wb,
                               rn: rn, reglist: reglist};
                  r_error <= 1'b0;
                  r_state <= ST_RDBASE;
               end
            end
            ST_RDBASE: begin
               r_mask  <= r_req.reglist;
               r_addr  <= w_start_addr;
               r_wbval <= w_wbval;
               if (w_n == 5'd0) begin
                  r_error <= 1'b1;
                  r_state <= ST_FIN;
               end else begin
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (!r_req.is_load) r_wdata <= rd_data;
               r_wait  <= '0;
               r_state <= ST_XFER;
            end
            ST_XFER: begin
               if (mem_ack) begin
                  r_mask <= w_mask_next;
                  r_addr <= r_addr + WORD_BYTES;
                  if (!w_last)
                     r_state <= ST_SETUP;
                  else if (r_req.wb && !w_skip_wb)
                     r_state <= ST_WBACK;
                  else
                     r_state <= ST_FIN;
               end else if (r_wait == WAIT_LAST) begin
                  r_error <= 1'b1;
                  r_state <= ST_FIN;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end
            ST_WBACK: r_state <= ST_FIN;
            ST_FIN:   r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_FIN);
   assign error     = done & r_error;
   assign mem_req   = w_in_xfer;
   assign mem_we    = w_in_xfer & ~r_req.is_load;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   // Register-file read port: base in RDBASE, store source in SETUP
   always_comb begin
      rd_addr = 4'd0;
      if (r_state == ST_RDBASE)
         rd_addr = r_req.rn;
      else if (r_state == ST_SETUP)
         rd_addr = w_cur;
   end

   // Register-file write strobes; state decode keeps them mutually exclusive
   always_comb begin
      write_reg = 1'b0;
      w_addr    = 4'd0;
      w_data    = 32'd0;
      write_pc  = 1'b0;
      pc_data   = 32'd0;
      if (r_state == ST_WBACK) begin
         write_reg = 1'b1;
         w_addr    = r_req.rn;
         w_data    = r_wbval;
      end else if (w_ld_ack) begin
         if (w_cur == PC_IDX) begin
            write_pc = 1'b1;
            pc_data  = mem_rdata & ~(WORD_BYTES - 32'd1);
         end else begin
            write_reg = 1'b1;
            w_addr    = w_cur;
            w_data    = mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Randomized self-checking bench for ldm_stm_seq with a behavioural
// register-file / memory model and an event scoreboard.
module tb_ldm_stm_seq;

   localparam int MAXW = 4;

   typedef struct packed { logic pc; logic [3:0] a; logic [31:0] d; } wr_t;
   typedef struct packed { logic we; logic [31:0] a; logic [31:0] d; } acc_t;

   logic        clk = 1'b0;
   logic        rst, start, is_load, pre, up, wb;
   logic [3:0]  rn;
   logic [15:0] reglist;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic        write_reg, write_pc;
   logic [3:0]  w_addr;
   logic [31:0] w_data, pc_data;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy, done, error;

   int tests = 0;
   int fails = 0;

   logic [31:0] regs [16];
   assign rd_data = regs[rd_addr];

   // memory responder controls (written by tests) and state (responder only)
   bit          resp_en = 1'b1;
   int          ack_lat = 0;
   int          ack_limit = 1 << 30;
   bit          rd_ovr_en = 1'b0;
   logic [31:0] rd_ovr = 32'd0;
   logic        man_ack = 1'b0;
   logic [31:0] man_rdata = 32'd0;
   logic        resp_ack = 1'b0;
   logic [31:0] resp_rdata = 32'd0;
   int          wcnt = 0;
   int          acks_given = 0;

   // scoreboard state (monitor only)
   wr_t  wr_q[$];
   acc_t acc_q[$];
   int   both_cnt = 0;
   int   req_cyc = 0;

   assign mem_ack   = resp_ack | man_ack;
   assign mem_rdata = man_ack ? man_rdata : resp_rdata;

   ldm_stm_seq #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load), .pre(pre),
      .up(up), .wb(wb), .rn(rn), .reglist(reglist), .rd_addr(rd_addr),
      .rd_data(rd_data), .write_reg(write_reg), .w_addr(w_addr),
      .w_data(w_data), .write_pc(write_pc), .pc_data(pc_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memval(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // memory: acks after ack_lat request cycles, up to ack_limit acks total
   always @(negedge clk) begin
      if (mem_req && resp_en && (acks_given < ack_limit)) begin
         if (wcnt >= ack_lat) begin
            resp_ack   = 1'b1;
            resp_rdata = rd_ovr_en ? rd_ovr : memval(mem_addr);
            acks_given = acks_given + 1;
         end else begin
            resp_ack = 1'b0;
         end
         wcnt = wcnt + 1;
      end else begin
         resp_ack = 1'b0;
         wcnt     = 0;
      end
   end

   // record every register write and completed memory access
   always @(posedge clk) begin
      if (write_reg) wr_q.push_back('{1'b0, w_addr, w_data});
      if (write_pc)  wr_q.push_back('{1'b1, 4'd15, pc_data});
      if (write_reg && write_pc) both_cnt = both_cnt + 1;
      if (mem_req && mem_ack) acc_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : 32'd0});
      if (mem_req) req_cyc = req_cyc + 1;
   end

   task automatic do_xfer(input logic ld, input logic p, input logic u, input logic w,
                          input logic [3:0] r, input logic [15:0] rl, input bit noise,
                          output bit got_done, output logic err, output int cyc, output int dcnt);
      got_done = 1'b0; err = 1'b0; cyc = 0; dcnt = 0;
      @(negedge clk);
      is_load = ld; pre = p; up = u; wb = w; rn = r; reglist = rl; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            dcnt++;
            if (!got_done) begin got_done = 1'b1; err = error; cyc = c; end
         end
         if (got_done && c >= cyc + 3) break;
         if (noise && !got_done && busy && c == 3) begin
            start = 1'b1; is_load = ~ld; pre = ~p; up = ~u; wb = ~w; rn = ~r; reglist = ~rl;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      tests++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin fails++;
         $display("FAIL reset_status got busy=%b done=%b error=%b want 0 0 0", busy, done, error); end
      tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++;
         $display("FAIL reset_mem_ctl got req=%b we=%b want 0 0", mem_req, mem_we); end
      tests++; if (write_reg !== 1'b0 || write_pc !== 1'b0) begin fails++;
         $display("FAIL reset_wr_strobes got wr=%b pc=%b want 0 0", write_reg, write_pc); end
      tests++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin fails++;
         $display("FAIL reset_mem_data got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
      tests++; if (w_addr !== 4'd0 || w_data !== 32'd0 || pc_data !== 32'd0 || rd_addr !== 4'd0) begin fails++;
         $display("FAIL reset_rf_data got w_addr=%h w_data=%h pc=%h rd=%h want 0", w_addr, w_data, pc_data, rd_addr); end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++;
         $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_ldm_ia();
      int a0, w0, cy, dc; bit gd; logic er; wr_t e0, e1;
      regs[1] = 32'h100; ack_lat = 1;
      a0 = acc_q.size(); w0 = wr_q.size();
      do_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0006, 1'b0, gd, er, cy, dc);
      tests++; if (!gd || dc != 1 || er !== 1'b0) begin fails++;
         $display("FAIL ldm_ia_done got done=%0d count=%0d err=%b want 1 1 0", gd, dc, er); end
      tests++; if (acc_q.size() - a0 != 2) begin fails++;
         $display("FAIL ldm_ia_nacc got %0d want 2", acc_q.size() - a0); end
      if (acc_q.size() - a0 >= 2) begin
         tests++; if (acc_q[a0] !== '{1'b0, 32'h100, 32'd0} || acc_q[a0+1] !== '{1'b0, 32'h104, 32'd0}) begin fails++;
            $display("FAIL ldm_ia_addr got %h %h want 100 104 (reads)", acc_q[a0].a, acc_q[a0+1].a); end
      end
      e0 = '{1'b0, 4'd1, memval(32'h100)}; e1 = '{1'b0, 4'd2, memval(32'h104)};
      tests++; if (wr_q.size() - w0 != 2) begin fails++;
         $display("FAIL ldm_ia_nwr got %0d want 2", wr_q.size() - w0); end
      if (wr_q.size() - w0 >= 2) begin
         tests++; if (wr_q[w0] !== e0 || wr_q[w0+1] !== e1) begin fails++;
            $display("FAIL ldm_ia_wr got %h %h want %h %h", wr_q[w0], wr_q[w0+1], e0, e1); end
      end
   endtask

   task automatic test_stm_db();
      int a0, w0, cy, dc; bit gd; logic er; wr_t ew;
      logic [31:0] ea [3]; logic [3:0] er_idx [3];
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      regs[13] = 32'h200; ack_lat = $urandom % 4;
      ea[0] = 32'h1F4; ea[1] = 32'h1F8; ea[2] = 32'h1FC;
      er_idx[0] = 4'd0; er_idx[1] = 4'd1; er_idx[2] = 4'd14;
      a0 = acc_q.size(); w0 = wr_q.size();
      do_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 16'h4003, 1'b0, gd, er, cy, dc);
      tests++; if (!gd || dc != 1 || er !== 1'b0) begin fails++;
         $display("FAIL stm_db_done got done=%0d count=%0d err=%b want 1 1 0", gd, dc, er); end
      tests++; if (acc_q.size() - a0 != 3) begin fails++;
         $display("FAIL stm_db_nacc got %0d want 3", acc_q.size() - a0); end
      for (int k = 0; k < 3; k++) begin
         if (acc_q.size() - a0 > k) begin
            tests++; if (acc_q[a0+k] !== '{1'b1, ea[k], regs[er_idx[k]]}) begin fails++;
               $display("FAIL stm_db_store%0d got %h want %h", k, acc_q[a0+k], {1'b1, ea[k], regs[er_idx[k]]}); end
         end
      end
      ew = '{1'b0, 4'd13, 32'h1F4};
      tests++; if (wr_q.size() - w0 != 1) begin fails++;
         $display("FAIL stm_db_nwr got %0d want 1", wr_q.size() - w0); end
      else begin
         tests++; if (wr_q[w0] !== ew) begin fails++;
            $display("FAIL stm_db_wback got %h want %h", wr_q[w0], ew); end
      end
   endtask

   task automatic test_ldm_pc();
      int a0, w0, cy, dc; bit gd; logic er; wr_t ew;
      regs[3] = 32'h4000; rd_ovr_en = 1'b1; rd_ovr = 32'h1237; ack_lat = 2;
      a0 = acc_q.size(); w0 = wr_q.size();
      do_xfer(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 16'h8000, 1'b0, gd, er, cy, dc);
      rd_ovr_en = 1'b0;
      tests++; if (!gd || er !== 1'b0) begin fails++;
         $display("FAIL ldm_pc_done got done=%0d err=%b want 1 0", gd, er); end
      tests++; if (acc_q.size() - a0 != 1) begin fails++;
         $display("FAIL ldm_pc_nacc got %0d want 1", acc_q.size() - a0); end
      else begin
         tests++; if (acc_q[a0].a !== 32'h4004) begin fails++;
            $display("FAIL ldm_pc_addr got %h want 00004004", acc_q[a0].a); end
      end
      ew = '{1'b1, 4'd15, 32'h1234};
      tests++; if (wr_q.size() - w0 != 1) begin fails++;
         $display("FAIL ldm_pc_nwr got %0d want 1", wr_q.size() - w0); end
      else begin
         tests++; if (wr_q[w0] !== ew) begin fails++;
            $display("FAIL ldm_pc_write got %h want %h", wr_q[w0], ew); end
      end
   endtask

   task automatic test_empty();
      int a0, w0, q0, cy, dc; bit gd; logic er;
      a0 = acc_q.size(); w0 = wr_q.size(); q0 = req_cyc;
      do_xfer(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 4'($urandom), 16'h0000, 1'b0, gd, er, cy, dc);
      tests++; if (!gd || er !== 1'b1 || cy > 3 || dc != 1) begin fails++;
         $display("FAIL empty_done got done=%0d err=%b cycles=%0d count=%0d want 1 1 <=3 1", gd, er, cy, dc); end
      tests++; if (req_cyc != q0 || acc_q.size() != a0 || wr_q.size() != w0) begin fails++;
         $display("FAIL empty_activity got req=%0d acc=%0d wr=%0d want 0 0 0", req_cyc - q0, acc_q.size() - a0, wr_q.size() - w0); end
   endtask

   task automatic test_timeout();
      int a0, w0, q0, cy, dc; bit gd; logic er;
      regs[5] = $urandom; resp_en = 1'b0;
      a0 = acc_q.size(); w0 = wr_q.size(); q0 = req_cyc;
      do_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 16'h0003, 1'b0, gd, er, cy, dc);
      resp_en = 1'b1;
      tests++; if (!gd || er !== 1'b1) begin fails++;
         $display("FAIL timeout_err got done=%0d err=%b want 1 1", gd, er); end
      tests++; if (req_cyc - q0 != MAXW) begin fails++;
         $display("FAIL timeout_req_cycles got %0d want %0d", req_cyc - q0, MAXW); end
      tests++; if (acc_q.size() != a0 || wr_q.size() != w0) begin fails++;
         $display("FAIL timeout_no_wback got acc=%0d wr=%0d want 0 0", acc_q.size() - a0, wr_q.size() - w0); end
   endtask

   task automatic test_abort_partial();
      int a0, w0, q0, cy, dc; bit gd; logic er; wr_t ew;
      regs[7] = 32'h800; ack_lat = 0; ack_limit = acks_given + 1;
      a0 = acc_q.size(); w0 = wr_q.size(); q0 = req_cyc;
      do_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 16'h0003, 1'b0, gd, er, cy, dc);
      ack_limit = 1 << 30;
      ew = '{1'b0, 4'd0, memval(32'h800)};
      tests++; if (!gd || er !== 1'b1 || req_cyc - q0 != 1 + MAXW) begin fails++;
         $display("FAIL abort_err got done=%0d err=%b req=%0d want 1 1 %0d", gd, er, req_cyc - q0, 1 + MAXW); end
      tests++; if (wr_q.size() - w0 != 1) begin fails++;
         $display("FAIL abort_nwr got %0d want 1", wr_q.size() - w0); end
      else begin
         tests++; if (wr_q[w0] !== ew) begin fails++;
            $display("FAIL abort_kept_write got %h want %h", wr_q[w0], ew); end
      end
      tests++; if (acc_q.size() - a0 != 1) begin fails++;
         $display("FAIL abort_nacc got %0d want 1", acc_q.size() - a0); end
   endtask

   task automatic test_random();
      acc_t exp_acc[$]; wr_t exp_wr[$];
      logic ld, p, u, w; logic [3:0] r; logic [15:0] rl; logic [31:0] base, lo, addr;
      int n, k, a0, w0, cy, dc; bit gd; logic er, exp_err;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 16; i++) regs[i] = $urandom;
         ld = 1'($urandom); p = 1'($urandom); u = 1'($urandom); w = 1'($urandom);
         r = 4'($urandom);
         rl = ($urandom % 3 == 0) ? (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'($urandom);
         if (t % 8 == 7) rl = 16'd0;
         if (t % 5 == 2) rl[r] = 1'b1;
         ack_lat = $urandom % MAXW;
         base = regs[r];
         n = $countones(rl);
         if (u) lo = base + (p ? 32'd4 : 32'd0);
         else   lo = base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
         exp_acc.delete(); exp_wr.delete();
         k = 0;
         for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
               addr = lo + 32'(4 * k); k++;
               if (ld) begin
                  exp_acc.push_back('{1'b0, addr, 32'd0});
                  if (i == 15) exp_wr.push_back('{1'b1, 4'd15, memval(addr) & 32'hFFFF_FFFC});
                  else         exp_wr.push_back('{1'b0, 4'(i), memval(addr)});
               end else begin
                  exp_acc.push_back('{1'b1, addr, regs[i]});
               end
            end
         end
         exp_err = (n == 0);
         if (n != 0 && w && !(ld && rl[r]))
            exp_wr.push_back('{1'b0, r, u ? base + 32'(4 * n) : base - 32'(4 * n)});
         a0 = acc_q.size(); w0 = wr_q.size();
         do_xfer(ld, p, u, w, r, rl, bit'($urandom % 2), gd, er, cy, dc);
         tests++; if (!gd || dc != 1 || er !== exp_err) begin fails++;
            $display("FAIL rnd%0d_done got done=%0d count=%0d err=%b want 1 1 %b", t, gd, dc, er, exp_err); end
         tests++; if (acc_q.size() - a0 != exp_acc.size()) begin fails++;
            $display("FAIL rnd%0d_nacc got %0d want %0d", t, acc_q.size() - a0, exp_acc.size()); end
         else begin
            for (int j = 0; j < exp_acc.size(); j++) begin
               tests++; if (acc_q[a0+j] !== exp_acc[j]) begin fails++;
                  $display("FAIL rnd%0d_acc%0d got %h want %h", t, j, acc_q[a0+j], exp_acc[j]); end
            end
         end
         tests++; if (wr_q.size() - w0 != exp_wr.size()) begin fails++;
            $display("FAIL rnd%0d_nwr got %0d want %0d", t, wr_q.size() - w0, exp_wr.size()); end
         else begin
            for (int j = 0; j < exp_wr.size(); j++) begin
               tests++; if (wr_q[w0+j] !== exp_wr[j]) begin fails++;
                  $display("FAIL rnd%0d_wr%0d got %h want %h", t, j, wr_q[w0+j], exp_wr[j]); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int w0; bit found; wr_t ew;
      regs[4] = 32'h1000; ack_lat = 0; ack_limit = acks_given + 1;
      w0 = wr_q.size(); found = 1'b0;
      @(negedge clk);
      is_load = 1'b1; pre = 1'b0; up = 1'b1; wb = 1'b1; rn = 4'd4; reglist = 16'h0006; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (mem_req && wr_q.size() == w0 + 1) begin found = 1'b1; break; end
      end
      tests++; if (!found) begin fails++;
         $display("FAIL rstmid_reach_xfer2 got reached=0 want 1"); end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++; if (mem_req !== 1'b0 || busy !== 1'b0 || write_reg !== 1'b0 || write_pc !== 1'b0) begin fails++;
         $display("FAIL rstmid_drop got req=%b busy=%b wr=%b pc=%b want 0 0 0 0", mem_req, busy, write_reg, write_pc); end
      rst = 1'b0; man_rdata = 32'hDEAD_BEEF; man_ack = 1'b1;
      repeat (3) @(posedge clk); #1;
      man_ack = 1'b0; ack_limit = 1 << 30;
      ew = '{1'b0, 4'd1, memval(32'h1000)};
      tests++; if (wr_q.size() - w0 != 1) begin fails++;
         $display("FAIL rstmid_late_ack got writes=%0d want 1", wr_q.size() - w0); end
      else begin
         tests++; if (wr_q[w0] !== ew) begin fails++;
            $display("FAIL rstmid_first_write got %h want %h", wr_q[w0], ew); end
      end
   endtask

   task automatic test_exclusive();
      tests++; if (both_cnt != 0) begin fails++;
         $display("FAIL strobe_exclusive got %0d overlapping cycles want 0", both_cnt); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0; wb = 1'b0;
      rn = 4'd0; reglist = 16'd0;
      for (int i = 0; i < 16; i++) regs[i] = 32'h0;
      repeat (3) @(posedge clk); #1;
      test_reset();
      test_ldm_ia();
      test_stm_db();
      test_ldm_pc();
      test_empty();
      test_timeout();
      test_abort_partial();
      test_random();
      test_reset_mid();
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
